// File: rtl/quad_esc_pwm.sv
// quad_esc_pwm: four-channel ESC PWM generator for a quadcopter.
// Motor speeds are pipelined through two stages (capture, scale to a pulse
// width), clamped and shadowed at every frame boundary, so a pulse width can
// only change between frames. All four channels share one frame counter, so
// their rising edges line up.
// Optional build macro ESC_FAILSAFE_EN: if too many frames pass without an
// upd strobe, boundary loads fall back to MIN_PULSE on every motor.
module quad_esc_pwm #(
    parameter int unsigned PERIOD          = 125000,
    parameter int unsigned MIN_PULSE       = 50000,
    parameter int unsigned SCALE           = 24,
    parameter int unsigned MAX_PULSE       = 100000,
    parameter int unsigned FAILSAFE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] frnt_spd,
    input  logic [10:0] bck_spd,
    input  logic [10:0] lft_spd,
    input  logic [10:0] rght_spd,
    input  logic        arm,
    input  logic        upd,
    output logic        frnt_pwm,
    output logic        bck_pwm,
    output logic        lft_pwm,
    output logic        rght_pwm,
    output logic        frame_start
);

    // Width of the scaled pulse (never overflows) and of the frame counter.
    localparam int unsigned WW = $clog2(MIN_PULSE + 2047 * SCALE + 1);
    localparam int unsigned CW = $clog2(PERIOD);

    localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
    localparam logic [WW-1:0] MIN_W    = WW'(MIN_PULSE);
    localparam logic [WW-1:0] SCALE_W  = WW'(SCALE);
    localparam logic [CW-1:0] MIN_HOLD = CW'(MIN_PULSE);

    // Clamp a scaled width to MAX_PULSE; the result always fits the counter
    // width because MAX_PULSE is below PERIOD.
    function automatic logic [CW-1:0] sat_width(input logic [WW-1:0] w);
        if (32'(w) > MAX_PULSE)
            return CW'(MAX_PULSE);
        return CW'(w);
    endfunction

    logic [10:0]   spd        [4];
    logic [10:0]   speed_p1   [4];
    logic [WW-1:0] width_p2   [4];
    logic [CW-1:0] width_hold [4];
    logic [3:0]    pwm;
    logic          armed_hold;
    logic [CW-1:0] cnt;
    logic          boundary;
    logic          fs_active;

    assign spd      = '{frnt_spd, bck_spd, lft_spd, rght_spd};
    assign boundary = (cnt == LAST);

    // Stage 1 captures raw speeds; stage 2 converts them to pulse widths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                speed_p1[i] <= '0;
                width_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                speed_p1[i] <= spd[i];
                width_p2[i] <= MIN_W + WW'(speed_p1[i]) * SCALE_W;
            end
        end
    end

    // Shared frame counter; frame_start marks the cnt==0 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= boundary ? '0 : cnt + CW'(1);
            frame_start <= boundary;
        end
    end

    // Shadow widths and arm at the boundary so a frame's pulse never changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_hold <= 1'b0;
            for (int i = 0; i < 4; i++)
                width_hold[i] <= '0;
        end else if (boundary) begin
            armed_hold <= arm;
            for (int i = 0; i < 4; i++)
                width_hold[i] <= fs_active ? MIN_HOLD : sat_width(width_p2[i]);
        end
    end

    // Pulse is high for cnt in 1..width_hold (compare uses pre-edge cnt).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                pwm[i] <= armed_hold && (cnt < width_hold[i]);
        end
    end

    assign frnt_pwm = pwm[0];
    assign bck_pwm  = pwm[1];
    assign lft_pwm  = pwm[2];
    assign rght_pwm = pwm[3];

`ifdef ESC_FAILSAFE_EN
    localparam int unsigned   MW       = $clog2(FAILSAFE_FRAMES + 1);
    localparam logic [MW-1:0] MISS_MAX = MW'(FAILSAFE_FRAMES);

    logic [MW-1:0] miss;
    logic          seen;

    // Count frames closed without an upd; an upd on the boundary edge
    // belongs to the frame being closed, so the new frame starts unseen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss <= '0;
            seen <= 1'b0;
        end else if (upd) begin
            miss <= '0;
            seen <= !boundary;
        end else if (boundary) begin
            if (!seen && miss != MISS_MAX)
                miss <= miss + MW'(1);
            seen <= 1'b0;
        end
    end

    assign fs_active = (miss == MISS_MAX);
`else
    logic unused_upd;

    assign unused_upd = upd;
    assign fs_active  = 1'b0;
`endif

endmodule

// File: tb/tb_quad_esc_pwm.sv
// Scoreboard bench for quad_esc_pwm: stimulus pushes the expected per-frame
// pulse widths; a negedge monitor measures every frame and compares.
module tb_quad_esc_pwm;

    localparam int P = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        arm, upd;
    logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm, frame_start;
    logic        c_frnt_pwm, c_bck_pwm, c_lft_pwm, c_rght_pwm, c_frame_start;

    always #5 clk = ~clk;

    quad_esc_pwm #(.PERIOD(P), .MIN_PULSE(1000), .SCALE(3), .MAX_PULSE(7500),
                   .FAILSAFE_FRAMES(4)) dut (
        .clk(clk), .rst(rst),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .arm(arm), .upd(upd),
        .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
        .frame_start(frame_start));

    quad_esc_pwm #(.PERIOD(P), .MIN_PULSE(1000), .SCALE(3), .MAX_PULSE(5000),
                   .FAILSAFE_FRAMES(4)) dut_c (
        .clk(clk), .rst(rst),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .arm(arm), .upd(upd),
        .frnt_pwm(c_frnt_pwm), .bck_pwm(c_bck_pwm), .lft_pwm(c_lft_pwm), .rght_pwm(c_rght_pwm),
        .frame_start(c_frame_start));

    typedef logic [3:0][15:0] exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int checks = 0;
    int passes = 0;

    logic [3:0] pwm_m, pwm_c;
    assign pwm_m = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};
    assign pwm_c = {c_rght_pwm, c_lft_pwm, c_bck_pwm, c_frnt_pwm};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic int clamp_c(input int w);
        return (w > 5000) ? 5000 : w;
    endfunction

    // Monitor: measure each frame, pop its expectation at the next frame_start.
    int len;
    int frame_no = 0;
    int hi_m[4], hi_c[4], first_m[4];

    always @(negedge clk) begin
        if (rst) begin
            len = 0;
            for (int m = 0; m < 4; m++) begin
                hi_m[m] = 0; hi_c[m] = 0; first_m[m] = -1;
            end
        end else begin
            len++;
            for (int m = 0; m < 4; m++) begin
                if (pwm_m[m]) begin
                    hi_m[m]++;
                    if (first_m[m] < 0) first_m[m] = len;
                end
                if (pwm_c[m]) hi_c[m]++;
            end
            if (frame_start) begin
                check($sformatf("frame_len_f%0d", frame_no), len, P);
                check($sformatf("clamp_dut_frame_start_f%0d", frame_no), int'(c_frame_start), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL scoreboard_f%0d: frame ended with no expectation queued", frame_no);
                end else begin
                    mon_e = exp_q.pop_front();
                    for (int m = 0; m < 4; m++) begin
                        check($sformatf("width_m%0d_f%0d", m, frame_no), hi_m[m], int'(mon_e[m]));
                        check($sformatf("clamped_width_m%0d_f%0d", m, frame_no), hi_c[m],
                              clamp_c(int'(mon_e[m])));
                        if (mon_e[m] != 16'd0)
                            check($sformatf("rise_offset_m%0d_f%0d", m, frame_no), first_m[m], 1);
                    end
                end
                frame_no++;
                len = 0;
                for (int m = 0; m < 4; m++) begin
                    hi_m[m] = 0; hi_c[m] = 0; first_m[m] = -1;
                end
            end
        end
    end

    // Stimulus helpers: pos tracks the current cnt value (cycles since frame_start).
    int   pos;
    logic upd_en;

    task automatic at_cnt(input int k);
        while (pos < k) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < P + 16);
        if (!frame_start) begin
            checks++;
            $display("FAIL frame_start_timeout: none within %0d cycles", n);
        end
        pos = 0;
    endtask

    task automatic frame_begin(input bit push, input int f, input int b, input int l, input int r);
        exp_t e;
        wait_fs();
        if (push) begin
            e[0] = 16'(f); e[1] = 16'(b); e[2] = 16'(l); e[3] = 16'(r);
            exp_q.push_back(e);
        end
        if (upd_en) begin
            at_cnt(20); upd = 1'b1;
            at_cnt(21); upd = 1'b0;
        end
    endtask

    task automatic set_speeds(input int v);
        frnt_spd = 11'(v); bck_spd = 11'(v); lft_spd = 11'(v); rght_spd = 11'(v);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arm = 1'b1; upd = 1'b0; upd_en = 1'b1; pos = 0;
        set_speeds(0);
        repeat (2) @(negedge clk);
        check("reset_pwm", int'(pwm_m), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_cnt", int'(dut.cnt), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        exp_q.push_back('0);                        // frame 0: not yet armed

        frame_begin(1, 1000, 1000, 1000, 1000);     // F1
        at_cnt(30); frnt_spd = 11'd100; lft_spd = 11'd2047;
        frame_begin(1, 1300, 1000, 7141, 1000);     // F2
        at_cnt(500); frnt_spd = 11'd200;            // mid-frame change, next frame only
        at_cnt(P - 3); bck_spd = 11'd100;           // last cycle still captured
        at_cnt(P - 2); rght_spd = 11'd100;          // too late for the next frame
        frame_begin(1, 1600, 1300, 7141, 1000);     // F3
`ifdef ESC_FAILSAFE_EN
        at_cnt(30); set_speeds(500); upd_en = 1'b0;
        frame_begin(1, 2500, 2500, 2500, 2500);     // F4 (upd seen in F3)
        repeat (4) frame_begin(1, 2500, 2500, 2500, 2500);  // F5..F8 while misses build
        frame_begin(1, 1000, 1000, 1000, 1000);     // F9: failsafe
        at_cnt(100); upd = 1'b1;
        at_cnt(101); upd = 1'b0;
        frame_begin(1, 2500, 2500, 2500, 2500);     // F10: recovered
        frame_begin(0, 0, 0, 0, 0);
`else
        at_cnt(30); set_speeds(0);
        frame_begin(1, 1000, 1000, 1000, 1000);     // F4
        at_cnt(300); arm = 1'b0;                    // current pulse must finish
        frame_begin(1, 0, 0, 0, 0);                 // F5: disarmed
        at_cnt(4000); arm = 1'b1;
        wait_fs();                                  // F6: interrupted by reset
        at_cnt(500);
        for (int m = 0; m < 4; m++)
            check($sformatf("rearmed_pwm_m%0d", m), int'(pwm_m[m]), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(pwm_m), 0);
        check("async_rst_pwm_clamp", int'(pwm_c), 0);
        check("async_rst_cnt", int'(dut.cnt), 0);
        check("async_rst_frame_start", int'(frame_start), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        exp_q.push_back('0);                        // F7: first frame after reset
        frame_begin(1, 1000, 1000, 1000, 1000);     // F8
        frame_begin(0, 0, 0, 0, 0);
`endif
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/quad_esc_pwm.md
Name: quad_esc_pwm

Overview:
- Downstream of the flight controller: takes the four 11-bit unsigned motor speeds (front, back, left, right) and drives four ESC PWM lines.
- Speeds are pipelined, scaled to pulse widths, clamped, and shadowed at frame boundaries, so widths change only between frames.
- A shared frame counter sets the ESC refresh rate. Default is 400 Hz at 50 MHz.

Parameters:
PERIOD, 125000, clock cycles per PWM frame (counter wraps PERIOD-1 -> 0)
MIN_PULSE, 50000, pulse width in cycles for speed 0
SCALE, 24, cycles added per speed LSB
MAX_PULSE, 100000, upper clamp on pulse width; must be < PERIOD
FAILSAFE_FRAMES, 4, frames without upd before failsafe (macro build only)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
frnt_spd  in  11  front motor speed, unsigned
bck_spd  in  11  back motor speed, unsigned
lft_spd  in  11  left motor speed, unsigned
rght_spd  in  11  right motor speed, unsigned
arm  in  1  enable pulses; sampled at frame boundary
upd  in  1  one-cycle strobe, new speeds valid (the flight controller's vld)
frnt_pwm, bck_pwm, lft_pwm, rght_pwm  out  1 each  ESC PWM outputs, registered
frame_start  out  1  one-cycle pulse during the cycle cnt==0 of each frame, registered

Behaviour:
- One clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - cnt=0, speed_q=0, width_q=0, width_hold=0, armed_hold=0.
  - All pwm=0, frame_start=0, failsafe state cleared.
  - Asserting rst mid-pulse forces all pwm low immediately, with no clock needed.
- Pipeline, per motor:
  - Stage 1: speed_q <= speed, every cycle.
  - Stage 2: width_q <= MIN_PULSE + speed_q*SCALE.
  - Arithmetic is unsigned and wide enough that no overflow occurs: $clog2(MIN_PULSE+2047*SCALE+1) bits.
  - A speed must be stable for 2 cycles before the boundary edge to affect the next frame.
- Frame counter: cnt increments every cycle and wraps from PERIOD-1 to 0. Width is $clog2(PERIOD).
- At the clock edge where cnt==PERIOD-1:
  - width_hold <= min(width_q, MAX_PULSE), per motor.
  - armed_hold <= arm.
  - frame_start <= 1.
- frame_start <= 0 on every other edge.
- PWM: pwm <= armed_hold && (cnt < width_hold), evaluated with the pre-edge values.
  - Rising edge comes 1 cycle after frame_start rises.
  - High for exactly width_hold cycles. Low for the rest of the frame.
- No pulse in the first frame after reset, because armed_hold=0. The first frame_start occurs PERIOD cycles after reset release.
- arm deasserted mid-frame: the current pulse completes unchanged, and no pulse is produced from the next frame on. Reassert: pulses resume at the next boundary.
- Mid-frame speed changes never alter the current frame's pulse; there are no runt or glitch pulses.
- The four motors share cnt, so all rising edges are simultaneous.
- upd has no effect unless ESC_FAILSAFE_EN is defined.

Optional Feature:
- Macro ESC_FAILSAFE_EN.
- Defined:
  - A frame-miss counter increments at each boundary edge with no upd seen during that frame. It saturates at FAILSAFE_FRAMES.
  - It clears when upd is seen.
  - While the counter equals FAILSAFE_FRAMES, boundary loads use width_hold <= MIN_PULSE for all motors, regardless of speed.
  - The first upd ends failsafe; normal loading resumes at the following boundary.
  - An upd in the same cycle as the boundary edge counts toward the frame being closed.
- Undefined: no miss counter exists, and upd is ignored.

Test Plan:
1. Params PERIOD=8192, MIN_PULSE=1000, SCALE=3, MAX_PULSE=7500. Reset, arm=1, all speeds 0 -> no pulse in frame 0; every later frame, all pwm high exactly 1000 cycles, rising 1 cycle after frame_start.
2. frnt_spd=100 -> 1300-cycle pulse. Change to 200 at cnt=500 -> that frame stays 1300, next frame 1600; other motors stay 1000.
3. lft_spd=2047 -> 7141 cycles. Rerun with MAX_PULSE=5000 -> clamped to 5000. Speed changed 1 cycle before the boundary edge -> old width used.
4. arm dropped at cnt=300 during a 1000-cycle pulse -> pulse still 1000 cycles, following frames low. arm raised mid-frame -> pulses resume at the next boundary.
5. rst asserted at cnt=500 while pwm is high -> all pwm low immediately, cnt=0. After release: frame_start first rises 8192 cycles later, and no pulse occurs in that first frame.
6. ESC_FAILSAFE_EN, FAILSAFE_FRAMES=4, speeds=500 with upd each frame -> 2500-cycle pulses. Stop upd -> after 4 missed frames pulses drop to 1000. One upd -> 2500 resumes at the following boundary.
